// File: rtl/lr35902_dbg_pkg.sv
// ---------------------------------------------------------------------------
// lr35902_dbg_pkg
//   Shared definitions for the LR35902 debug UART transmit scheduler:
//   serializer state encoding, default bit period and the largest number of
//   requesters the arbiter is built to handle.
// ---------------------------------------------------------------------------
package lr35902_dbg_pkg;

  // Serializer frame phases. IDLE is the only phase in which a new byte can
  // be accepted from a requester.
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  // cpu_clk cycles per UART bit when the parent does not override it
  localparam int DEF_BAUD_DIV = 12;

  // Arbiter datapaths are padded to this many requesters
  localparam int MAX_NUM_REQ = 4;

  // Width of a counter that runs 0..div-1; a divider of 1 still needs a bit
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/lr35902_uart_tx_ser.sv
// ---------------------------------------------------------------------------
// lr35902_uart_tx_ser
//   8N1 UART serializer. A byte offered with i_start while idle is latched
//   and sent as START(0), eight data bits LSB first, STOP(1); each bit lasts
//   BAUD_DIV clocks. After STOP the block spends at least one cycle idle.
//
//   Ports:
//     i_clk    clock, all state changes on its rising edge
//     i_reset  synchronous active-high reset, aborts any frame in progress
//     i_start  accept i_data and begin a frame (only honoured while idle)
//     i_data   byte to transmit
//     o_tx     serial line, idle high
//     o_idle   high while the serializer can accept a byte
// ---------------------------------------------------------------------------
module lr35902_uart_tx_ser
  import lr35902_dbg_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_idle
);

  localparam int             CW       = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BAUD_DIV - 1);

  ser_state_e    r_state;
  ser_state_e    w_stateNxt;
  logic [CW-1:0] r_baudCnt;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          w_bitEnd;

  assign w_bitEnd = (r_baudCnt == CNT_LAST);

  // Next-state logic: each non-idle phase advances only on the last clock of
  // its bit period; DATA additionally waits for the eighth bit.
  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      SER_IDLE:  if (i_start) w_stateNxt = SER_START;
      SER_START: if (w_bitEnd) w_stateNxt = SER_DATA;
      SER_DATA:  if (w_bitEnd && (r_bitCnt == 3'd7)) w_stateNxt = SER_STOP;
      SER_STOP:  if (w_bitEnd) w_stateNxt = SER_IDLE;
      default:   w_stateNxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= SER_IDLE;
    else         r_state <= w_stateNxt;
  end

  // Bit timing and shift register. The byte is captured on the accept cycle
  // so later changes on the requester side cannot disturb the frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
    end else if (r_state == SER_IDLE) begin
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      if (i_start) r_shift <= i_data;
    end else begin
      r_baudCnt <= w_bitEnd ? '0 : r_baudCnt + 1'b1;
      if ((r_state == SER_DATA) && w_bitEnd) begin
        r_bitCnt <= r_bitCnt + 3'd1;
        r_shift  <= {1'b0, r_shift[7:1]};
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      SER_START: o_tx = 1'b0;
      SER_DATA:  o_tx = r_shift[0];
      default:   o_tx = 1'b1;
    endcase
  end

  assign o_idle = (r_state == SER_IDLE);

endmodule

// File: rtl/lr35902_dbg_tx_sched.sv
// ---------------------------------------------------------------------------
// lr35902_dbg_tx_sched
//   Shares one 8N1 UART serializer among NUM_REQ (2..4) byte requesters.
//   Arbitration happens only while the serializer is idle: round-robin from
//   r_rrPtr, except that a packet in progress (a byte sent with last=0) locks
//   every following grant to the same requester until its last byte.
//
//   Ports:
//     i_cpu_clk    sole clock
//     i_reset      synchronous active-high reset
//     i_req_valid  per-requester byte available
//     i_req_data   per-requester byte, requester i at [8i+7:8i]
//     i_req_last   final byte of requester i's packet
//     o_req_ready  one-hot combinational accept strobe
//     o_tx         UART line, idle high
//     o_busy       frame in flight or packet lock held
//     o_grant_id   requester owning the current or last frame
// ---------------------------------------------------------------------------
module lr35902_dbg_tx_sched
  import lr35902_dbg_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int NUM_REQ  = 3
) (
  input  logic                 i_cpu_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic [1:0]           o_grant_id
);

  logic       r_lock;
  logic [1:0] r_rrPtr;
  logic [1:0] r_grantId;

  logic                     w_serTx;
  logic                     w_serIdle;
  logic                     w_found;
  logic [1:0]               w_sel;
  logic [2:0]               w_idx;
  logic                     w_xfer;
  logic [7:0]               w_selData;
  logic                     w_selLast;
  logic [MAX_NUM_REQ-1:0]   w_validPad;
  logic [MAX_NUM_REQ-1:0]   w_lastPad;
  logic [8*MAX_NUM_REQ-1:0] w_dataPad;
  logic [MAX_NUM_REQ-1:0]   w_oneHot;

  // Pad the requester buses to the maximum width so a 2-bit index always
  // selects exactly within range regardless of NUM_REQ.
  assign w_validPad = MAX_NUM_REQ'(i_req_valid);
  assign w_lastPad  = MAX_NUM_REQ'(i_req_last);
  assign w_dataPad  = (8*MAX_NUM_REQ)'(i_req_data);

  // Grant selection. While locked only the packet owner (the last granted
  // requester) may be chosen, so a silent owner stalls everyone. Otherwise
  // scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and take the first valid one.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    if (r_lock) begin
      w_found = w_validPad[r_grantId];
      w_sel   = r_grantId;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = {1'b0, r_rrPtr} + 3'(k);
        if (w_idx >= 3'(NUM_REQ)) w_idx = w_idx - 3'(NUM_REQ);
        if (!w_found && w_validPad[w_idx[1:0]]) begin
          w_found = 1'b1;
          w_sel   = w_idx[1:0];
        end
      end
    end
  end

  // A transfer only happens in serializer idle; reset masks it so a pending
  // handshake never slips through on a reset cycle.
  assign w_xfer      = w_serIdle && w_found && !i_reset;
  assign w_oneHot    = MAX_NUM_REQ'(1) << w_sel;
  assign o_req_ready = w_xfer ? NUM_REQ'(w_oneHot) : '0;
  assign w_selData   = w_dataPad[{w_sel, 3'b000} +: 8];
  assign w_selLast   = w_lastPad[w_sel];

  // Lock and round-robin bookkeeping. The pointer moves past a requester only
  // when its packet completes, so a multi-byte packet is never split.
  always_ff @(posedge i_cpu_clk) begin
    if (i_reset) begin
      r_lock    <= 1'b0;
      r_rrPtr   <= '0;
      r_grantId <= '0;
    end else if (w_xfer) begin
      r_grantId <= w_sel;
      if (w_selLast) begin
        r_lock  <= 1'b0;
        r_rrPtr <= (w_sel == 2'(NUM_REQ - 1)) ? 2'd0 : w_sel + 2'd1;
      end else begin
        r_lock  <= 1'b1;
      end
    end
  end

  lr35902_uart_tx_ser #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .i_clk   (i_cpu_clk),
    .i_reset (i_reset),
    .i_start (w_xfer),
    .i_data  (w_selData),
    .o_tx    (w_serTx),
    .o_idle  (w_serIdle)
  );

  // Outputs are forced to their reset values while reset is held, even
  // before the first reset edge has cleared the registers.
  assign o_tx       = i_reset ? 1'b1 : w_serTx;
  assign o_busy     = !i_reset && (!w_serIdle || r_lock);
  assign o_grant_id = i_reset ? 2'd0 : r_grantId;

endmodule

// File: tb/tb_lr35902_dbg_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_lr35902_dbg_tx_sched
//   Self-checking bench for lr35902_dbg_tx_sched with BAUD_DIV=4, NUM_REQ=3.
//   Requesters are byte queues; a reference model tracks frame timing, the
//   round-robin pointer and packet lock as plain integers and predicts the
//   ready/tx/busy/grant outputs every cycle.
// ---------------------------------------------------------------------------
module tb_lr35902_dbg_tx_sched;

  localparam int BD     = 4;
  localparam int NR     = 3;
  localparam int FRAME  = 10 * BD;
  localparam int PERIOD = FRAME + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] reqValid = '0;
  logic [8*NR-1:0] reqData = '0;
  logic [NR-1:0] reqLast = '0;
  logic [NR-1:0] dutReady;
  logic          dutTx;
  logic          dutBusy;
  logic [1:0]    dutGid;

  always #5 clk = ~clk;

  lr35902_dbg_tx_sched #(
    .BAUD_DIV (BD),
    .NUM_REQ  (NR)
  ) dut (
    .i_cpu_clk   (clk),
    .i_reset     (reset),
    .i_req_valid (reqValid),
    .i_req_data  (reqData),
    .i_req_last  (reqLast),
    .o_req_ready (dutReady),
    .o_tx        (dutTx),
    .o_busy      (dutBusy),
    .o_grant_id  (dutGid)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Requester byte queues, plus a per-requester enable used to gap valid
  logic [7:0]    qd[NR][64];
  logic          ql[NR][64];
  int            head[NR];
  int            tail[NR];
  logic [NR-1:0] en = '1;

  // Reference model state: remaining frame cycles, lock, pointer, owner
  int         mCnt = 0;
  logic       mLock = 1'b0;
  int         mRr = 0;
  int         mGid = 0;
  logic [7:0] mByte = '0;

  // Model predictions for the current cycle
  logic [NR-1:0] eReady;
  logic          eTx;
  logic          eBusy;
  logic [1:0]    eGid;
  int            eSel;
  logic [NR-1:0] sReady;

  // DUT-observed transfers (requester index and cycle)
  int obsId[$];
  int obsCyc[$];

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    en = '1;
    obsId.delete();
    obsCyc.delete();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][tail[r]] = d;
    ql[r][tail[r]] = l;
    tail[r]++;
  endtask

  // Requesters present their head byte; while a frame is running the data and
  // last lines are scrambled since they must not matter then.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && head[i] < tail[i]) begin
        reqValid[i] = 1'b1;
        reqData[8*i +: 8] = (mCnt > 0) ? 8'($urandom) : qd[i][head[i]];
        reqLast[i] = (mCnt > 0) ? 1'($urandom) : ql[i][head[i]];
      end else begin
        reqValid[i] = 1'b0;
        reqData[8*i +: 8] = 8'($urandom);
        reqLast[i] = 1'($urandom);
      end
    end
  endtask

  // Predict outputs from the model state and the current requester inputs
  task automatic model_eval();
    bit found;
    int idx;
    int bitNo;
    found = 0;
    eReady = '0;
    eSel = 0;
    if (!reset && mCnt == 0) begin
      if (mLock) begin
        if (reqValid[mGid]) begin
          found = 1;
          eSel = mGid;
        end
      end else begin
        for (int k = 0; k < NR; k++) begin
          idx = (mRr + k) % NR;
          if (!found && reqValid[idx]) begin
            found = 1;
            eSel = idx;
          end
        end
      end
      if (found) eReady[eSel] = 1'b1;
    end
    if (reset || mCnt == 0) begin
      eTx = 1'b1;
    end else begin
      bitNo = (FRAME - mCnt) / BD;
      if (bitNo == 0)      eTx = 1'b0;
      else if (bitNo <= 8) eTx = mByte[bitNo-1];
      else                 eTx = 1'b1;
    end
    eBusy = !reset && (mCnt > 0 || mLock);
    eGid = reset ? 2'd0 : 2'(mGid);
    sReady = dutReady;
  endtask

  // Advance one clock: log the DUT handshake, then update the model
  task automatic step();
    int id;
    @(posedge clk);
    cyc++;
    if (sReady != '0) begin
      id = 0;
      for (int k = NR - 1; k >= 0; k--) if (sReady[k]) id = k;
      obsId.push_back(id);
      obsCyc.push_back(cyc);
    end
    if (reset) begin
      mCnt = 0;
      mLock = 1'b0;
      mRr = 0;
      mGid = 0;
    end else if (mCnt > 0) begin
      mCnt--;
    end else if (eReady != '0) begin
      mGid = eSel;
      mByte = reqData[8*eSel +: 8];
      mCnt = FRAME;
      if (reqLast[eSel]) begin
        mLock = 1'b0;
        mRr = (eSel + 1) % NR;
      end else begin
        mLock = 1'b1;
      end
      head[eSel]++;
    end
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      drive();
      @(negedge clk);
      model_eval();
      step();
    end
    reset = 1'b0;
  endtask

  // Outputs held at reset values while reset is high, even with valid bytes
  task automatic test_reset();
    clear_queues();
    for (int i = 0; i < NR; i++) push(i, 8'($urandom), 1'b1);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {3'b000, 1'b1, 1'b0, 2'd0}) begin
        bad++;
        $display("[TB] FAIL reset_outputs c=%0d got=%b exp=%b", c,
                 {dutReady, dutTx, dutBusy, dutGid}, {3'b000, 1'b1, 1'b0, 2'd0});
      end
      step();
    end
  endtask

  // One 0xA5 byte from requester 0: waveform, decoded byte, busy length
  task automatic test_single_byte();
    logic txS[64];
    int busyN;
    logic [7:0] dec;
    clear_queues();
    push(0, 8'hA5, 1'b1);
    apply_reset(2);
    busyN = 0;
    for (int c = 0; c < 45; c++) begin
      drive();
      @(negedge clk);
      model_eval();
      txS[c] = dutTx;
      if (dutBusy) busyN++;
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL single cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      step();
    end
    for (int b = 0; b < 8; b++) dec[b] = txS[1 + BD*(b+1) + BD/2];
    total++;
    if (busyN !== 40) begin
      bad++;
      $display("[TB] FAIL single_busy_len got=%0d exp=40", busyN);
    end
    total++;
    if (txS[1 + BD/2] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_start got=%b exp=0", txS[1 + BD/2]);
    end
    total++;
    if (dec !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL single_byte got=%h exp=a5", dec);
    end
    total++;
    if (txS[1 + 9*BD + BD/2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_stop got=%b exp=1", txS[1 + 9*BD + BD/2]);
    end
  endtask

  // All three requesters valid after reset: order 0,1,2,0 at 41-cycle spacing
  task automatic test_contention();
    int expOrd[4] = '{0, 1, 2, 0};
    clear_queues();
    for (int i = 0; i < NR; i++) begin
      push(i, 8'($urandom), 1'b1);
      push(i, 8'($urandom), 1'b1);
    end
    apply_reset(2);
    for (int c = 0; c < 4*PERIOD + 3; c++) begin
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL contention cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= obsId.size()) begin
        bad++;
        $display("[TB] FAIL contention_grant%0d got=none exp=%0d", k, expOrd[k]);
      end else if (obsId[k] !== expOrd[k]) begin
        bad++;
        $display("[TB] FAIL contention_grant%0d got=%0d exp=%0d", k, obsId[k], expOrd[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (k >= obsCyc.size()) begin
        bad++;
        $display("[TB] FAIL contention_period%0d got=none exp=%0d", k, PERIOD);
      end else if (obsCyc[k] - obsCyc[k-1] !== PERIOD) begin
        bad++;
        $display("[TB] FAIL contention_period%0d got=%0d exp=%0d", k,
                 obsCyc[k] - obsCyc[k-1], PERIOD);
      end
    end
  endtask

  // Requester 1 sends a two-byte packet while 0 and 2 wait: 1,1 then 2
  task automatic test_lock();
    int expOrd[3] = '{1, 1, 2};
    clear_queues();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b1);
    push(0, 8'($urandom), 1'b1);
    push(2, 8'($urandom), 1'b1);
    en = 3'b010;
    apply_reset(2);
    for (int c = 0; c < 3*PERIOD + 3; c++) begin
      if (c == 1) en = 3'b111;
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL lock cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (k >= obsId.size()) begin
        bad++;
        $display("[TB] FAIL lock_grant%0d got=none exp=%0d", k, expOrd[k]);
      end else if (obsId[k] !== expOrd[k]) begin
        bad++;
        $display("[TB] FAIL lock_grant%0d got=%0d exp=%0d", k, obsId[k], expOrd[k]);
      end
    end
  endtask

  // Packet owner goes silent for 20 cycles: line idle, busy held, no grant
  task automatic test_lock_stall();
    clear_queues();
    push(1, 8'h11, 1'b0);
    push(1, 8'h33, 1'b1);
    push(0, 8'($urandom), 1'b1);
    en = 3'b010;
    apply_reset(2);
    for (int c = 0; c < 61 + 2*PERIOD + 3; c++) begin
      if (c == 1)  en[0] = 1'b1;
      if (c == 41) en[1] = 1'b0;
      if (c == 61) en[1] = 1'b1;
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL stall cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      if (c >= 41 && c < 61) begin
        total++;
        if ({dutTx, dutBusy, dutReady} !== {1'b1, 1'b1, 3'b000}) begin
          bad++;
          $display("[TB] FAIL stall_window c=%0d got tx,busy,ready=%b exp=11000", c,
                   {dutTx, dutBusy, dutReady});
        end
      end
      step();
    end
    total++;
    if (obsId.size() < 3) begin
      bad++;
      $display("[TB] FAIL stall_grants got=%0d exp=3", obsId.size());
    end else begin
      if (obsId[1] !== 1 || obsCyc[1] - obsCyc[0] !== 61) begin
        bad++;
        $display("[TB] FAIL stall_resume got id=%0d gap=%0d exp id=1 gap=61",
                 obsId[1], obsCyc[1] - obsCyc[0]);
      end
      total++;
      if (obsId[2] !== 0) begin
        bad++;
        $display("[TB] FAIL stall_after got=%0d exp=0", obsId[2]);
      end
    end
  endtask

  // Reset 13 cycles into a frame: line high next cycle, requester 0 first
  task automatic test_reset_midframe();
    clear_queues();
    push(0, 8'($urandom), 1'b1);
    push(0, 8'($urandom), 1'b1);
    push(1, 8'($urandom), 1'b1);
    push(2, 8'($urandom), 1'b1);
    apply_reset(2);
    for (int c = 0; c < 60; c++) begin
      if (c == 13) reset = 1'b1;
      if (c == 14) reset = 1'b0;
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL midreset cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      if (c == 14) begin
        total++;
        if (dutTx !== 1'b1) begin
          bad++;
          $display("[TB] FAIL midreset_tx got=%b exp=1", dutTx);
        end
      end
      step();
    end
    total++;
    if (obsId.size() < 2) begin
      bad++;
      $display("[TB] FAIL midreset_regrant got=none exp=0");
    end else if (obsId[1] !== 0 || obsCyc[1] - obsCyc[0] !== 14) begin
      bad++;
      $display("[TB] FAIL midreset_regrant got id=%0d gap=%0d exp id=0 gap=14",
               obsId[1], obsCyc[1] - obsCyc[0]);
    end
  endtask

  // Random packets with random valid gaps, every cycle checked against model
  task automatic test_random();
    int pushed;
    int guard;
    int nPk;
    int len;
    bit allDone;
    clear_queues();
    pushed = 0;
    for (int r = 0; r < NR; r++) begin
      nPk = $urandom_range(1, 3);
      for (int p = 0; p < nPk; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          push(r, 8'($urandom), (b == len - 1));
          pushed++;
        end
      end
    end
    apply_reset(2);
    guard = 0;
    allDone = 0;
    while (!allDone && guard < 4000) begin
      en = 3'($urandom);
      drive();
      @(negedge clk);
      model_eval();
      total++;
      if ({dutReady, dutTx, dutBusy, dutGid} !== {eReady, eTx, eBusy, eGid}) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%b exp=%b", cyc,
                 {dutReady, dutTx, dutBusy, dutGid}, {eReady, eTx, eBusy, eGid});
      end
      step();
      guard++;
      allDone = (mCnt == 0);
      for (int i = 0; i < NR; i++) if (head[i] < tail[i]) allDone = 0;
    end
    total++;
    if (!allDone) begin
      bad++;
      $display("[TB] FAIL random_timeout got=%0d cycles exp=drained", guard);
    end
    total++;
    if (obsId.size() !== pushed) begin
      bad++;
      $display("[TB] FAIL random_count got=%0d exp=%0d", obsId.size(), pushed);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_contention();
    test_lock();
    test_lock_stall();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
